// File: rtl/cmp_serial_32bit.sv
// Digit-serial magnitude comparator: scans operands LSB digit first, DIGIT bits per clock,
// and returns held gt/lt/eq flags through a start/busy/done handshake.
module cmp_serial_32bit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0]       RES_EQ   = 2'b00;
  localparam logic [1:0]       RES_GT   = 2'b01;
  localparam logic [1:0]       RES_LT   = 2'b10;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [1:0]       run_res_q, run_res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [2:0]       flags_q, flags_d;
  logic [1:0]       dig_res, res_nx;

  function automatic logic [1:0] dig_cmp(input logic [DIGIT-1:0] x, input logic [DIGIT-1:0] y);
    if (x > y) return RES_GT;
    if (x < y) return RES_LT;
    return RES_EQ;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A differing digit overrides the running result: later digits are more significant.
  assign dig_res = dig_cmp(sa_q[DIGIT-1:0], sb_q[DIGIT-1:0]);
  assign res_nx  = (dig_res != RES_EQ) ? dig_res : run_res_q;

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    run_res_d = run_res_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    flags_d   = flags_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping both MSBs maps two's-complement order onto unsigned order.
          sa_d      = a ^ (is_signed ? MSB_MASK : '0);
          sb_d      = b ^ (is_signed ? MSB_MASK : '0);
          run_res_d = RES_EQ;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        sa_d      = sa_q >> DIGIT;
        sb_d      = sb_q >> DIGIT;
        run_res_d = res_nx;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          flags_d = {res_nx == RES_GT, res_nx == RES_LT, res_nx == RES_EQ};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    gt   = flags_q[2];
    lt   = flags_q[1];
    eq   = flags_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_res_q <= RES_EQ;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      flags_q   <= 3'b000;
    end else begin
      run_res_q <= run_res_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      flags_q   <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    sa_q <= sa_d;
    sb_q <= sb_d;
  end

endmodule

// File: tb/tb_cmp_serial_32bit.sv
// Scoreboard bench for cmp_serial_32bit at DIGIT = 4, 1 and 32 (N = 8, 32, 1).
module tb_cmp_serial_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  busy_w, done_w, gt_w, lt_w, eq_w;

  int sel = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [2:0] flags;
    int         due;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  cmp_serial_32bit #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .is_signed(is_signed),
    .busy(busy_w[0]), .done(done_w[0]), .gt(gt_w[0]), .lt(lt_w[0]), .eq(eq_w[0]));
  cmp_serial_32bit #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .is_signed(is_signed),
    .busy(busy_w[1]), .done(done_w[1]), .gt(gt_w[1]), .lt(lt_w[1]), .eq(eq_w[1]));
  cmp_serial_32bit #(.WIDTH(32), .DIGIT(32)) u_d32 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .is_signed(is_signed),
    .busy(busy_w[2]), .done(done_w[2]), .gt(gt_w[2]), .lt(lt_w[2]), .eq(eq_w[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (inst %0d, cycle %0d): got %0h, expected %0h", tag, sel, cyc, got, exp);
  endtask

  function automatic logic [2:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic g, l;
    if (s) begin
      g = $signed(x) > $signed(y);
      l = $signed(x) < $signed(y);
    end else begin
      g = x > y;
      l = x < y;
    end
    return {g, l, x == y};
  endfunction

  function automatic int nn(input int s);
    case (s)
      0:       return 8;
      1:       return 32;
      default: return 1;
    endcase
  endfunction

  function automatic logic [2:0] flags_now();
    return {gt_w[sel], lt_w[sel], eq_w[sel]};
  endfunction

  function automatic logic [4:0] outs_now();
    return {busy_w[sel], done_w[sel], gt_w[sel], lt_w[sel], eq_w[sel]};
  endfunction

  always @(negedge clk) begin
    if (done_w[sel]) begin
      if (sb_q.size() == 0) check_val("spurious_done", 1, 0);
      else begin
        mon_e = sb_q.pop_front();
        check_val("flags", {29'd0, flags_now()}, {29'd0, mon_e.flags});
        check_val("latency", cyc, mon_e.due);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic go(input logic [31:0] av, input logic [31:0] bv, input logic s, input bit push);
    for (int i = 0; i < 400 && busy_w[sel]; i++) @(negedge clk);
    a = av; b = bv; is_signed = s; start = 1'b1;
    if (push) sb_q.push_back('{model(av, bv, s), cyc + 1 + nn(sel)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy_w[sel]) break;
    end
    check_val("drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  logic [31:0] va[6] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h1000_0000, 32'h7FFF_FFFF};
  logic [31:0] vb[6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0FFF_FFFF, 32'h8000_0000};
  logic        vs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int cnt;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_state", {27'd0, outs_now()}, 0);
      rst = 1'b0;
      @(negedge clk);

      go(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
      cnt = 0;
      for (int i = 0; i < 100 && busy_w[sel]; i++) begin
        cnt++;
        @(negedge clk);
      end
      check_val("busy_len", cnt, nn(sel));
      wait_idle();

      for (int i = 0; i < 6; i++) begin
        go(va[i], vb[i], vs[i], 1'b1);
        wait_idle();
      end
      for (int i = 0; i < 4; i++) begin
        go($urandom, $urandom, 1'(i % 2), 1'b1);
        wait_idle();
      end

      if (nn(sel) >= 8) begin
        go(32'h0000_00F0, 32'h0000_0F00, 1'b0, 1'b1);
        @(negedge clk);
        a = 32'h0000_0F00; b = 32'h0000_00F0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check_val("ignored_start_flags", {29'd0, flags_now()}, 32'b010);

        go(32'h7000_0000, 32'h0000_0001, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_val("async_rst", {27'd0, outs_now()}, 0);
        @(negedge clk);
        rst = 1'b0;
      end

      go(32'd5, 32'd9, 1'b0, 1'b1);
      wait_idle();
      check_val("after_rst_lt", {29'd0, flags_now()}, 32'b010);

      go(32'd9, 32'd5, 1'b0, 1'b1);
      for (int i = 0; i < 400; i++) begin
        if (done_w[sel]) break;
        @(negedge clk);
      end
      a = 32'd5; b = 32'd9; is_signed = 1'b0; start = 1'b1;
      sb_q.push_back('{model(32'd5, 32'd9, 1'b0), cyc + 1 + nn(sel)});
      @(negedge clk);
      start = 1'b0;
      if (nn(sel) > 1) begin
        check_val("b2b_busy", {31'd0, busy_w[sel]}, 1);
        check_val("b2b_held", {29'd0, flags_now()}, 32'b100);
      end
      wait_idle();
      check_val("b2b_final", {29'd0, flags_now()}, 32'b010);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cmp_serial_32bit.md
# cmp_serial_32bit

Multi-cycle, digit-serial magnitude comparator for the CPU load/compare datapath, the area-saving counterpart of the single-cycle MSB-first flat comparator. It scans its operands in the opposite direction (LSB digit first) and processes DIGIT bits per clock. The final gt/lt/eq result is returned through a start/busy/done handshake. It supports unsigned and two's-complement signed comparison.

## Interface
- WIDTH, 32, operand width in bits
- DIGIT, 4, bits examined per clock; must divide WIDTH exactly; N = WIDTH/DIGIT digit cycles
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  left operand; captured on the accepted start edge
- b  input  WIDTH  right operand; captured on the accepted start edge
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; captured with a and b
- busy  output  1  comparison in progress
- done  output  1  one-cycle pulse; result flags valid and updated
- gt  output  1  a > b (registered, held)
- lt  output  1  a < b (registered, held)
- eq  output  1  a == b (registered, held)

## Operation
- States are IDLE and RUN. Internal registers:
  - sa, sb: WIDTH-bit shift registers
  - run_res: 2-bit running result, encoded EQ/GT/LT
  - cnt: digit counter, 0..N-1
- IDLE, start=1: load sa=a and sb=b. If is_signed=1, invert bit WIDTH-1 of both; signed order is the unsigned order with MSBs flipped. Set run_res=EQ, cnt=0, then go to RUN.
- RUN, each cycle:
  - Compare the low DIGIT bits of sa and sb as unsigned values.
  - If they differ, run_res takes that digit's result (GT or LT), overriding any earlier value, because later digits are more significant.
  - If they are equal, run_res is unchanged.
  - Shift sa and sb right by DIGIT. Increment cnt.
- RUN, cnt=N-1: the digit compare for this cycle is still applied. Then load gt/lt/eq from the final run_res, pulse done, clear busy, and return to IDLE.
- gt, lt and eq are exactly one-hot after the first done. They change only at a done edge and are never disturbed while busy.
- start while busy=1 is ignored. It is not queued, and the captured operands are unaffected.
- Changes to a, b or is_signed after capture have no effect on the running comparison.
- The digit compare uses no arithmetic wider than DIGIT bits. cnt is ceil(log2(N)) bits wide, with a minimum of 1.

## Timing
- Reset (asynchronous, any time, including mid-RUN): state=IDLE, busy=0, done=0, gt=0, lt=0, eq=0, run_res=EQ, cnt=0. Any in-flight comparison is discarded, and no done is issued for it.
- The start edge k is accepted when busy=0. busy=1 from edge k until edge k+N.
- Digits are processed on edges k+1 through k+N.
- At edge k+N: flags are updated, done=1 for exactly one cycle, and busy=0.
- Latency is start edge to done edge = N cycles (8 for the defaults). Throughput is one result per N cycles.
- Back-to-back: start=1 during the cycle where done=1 is accepted at the next edge. The held flags keep their previous result until the new done.
- DIGIT=WIDTH gives N=1: done one cycle after start, and busy high for one cycle.

## Test plan
- a=0x1234_5678, b=0x1234_5678, unsigned; start at edge k -> done only at edge k+8, eq=1, gt=lt=0, busy high for exactly 8 cycles.
- a=0x8000_0000, b=0x0000_0001: unsigned -> gt=1; repeat with is_signed=1 -> lt=1. a=0xFFFF_FFFF, b=0x0000_0000, signed -> lt=1.
- a=0x0000_0002, b=0x0000_0001 -> gt=1 (low-digit difference). a=0x1000_0000, b=0x0FFF_FFFF -> gt=1 (a high digit overrides opposite low digits).
- Pulse start=1 with new operands at cycles 2 and 5 of a busy period -> ignored; the result matches the first operands; exactly one done.
- Assert rst in cycle 4 of RUN -> all outputs go to 0 immediately. After release, a fresh start with a=5, b=9 -> lt=1 after 8 cycles, with no spurious done.
- Assert start during the done cycle with swapped operands -> the first result is held for 8 more cycles, then the opposite flag appears. Rerun the suite at DIGIT=1 (N=32) and DIGIT=32 (N=1).
